// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants for the frame receiver and the key decoder.
package ps2_pkg;

  localparam int unsigned PS2_DATA_BITS  = 8;
  localparam logic [7:0]  PS2_BREAK_CODE = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_rx_state_t;

  // Returns 1 when data bits plus parity bit hold an odd number of ones.
  function automatic logic ps2_odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser plus saturating-count glitch filter for one open-collector PS/2 line.
// The filtered output idles high and only changes after FILTER_LEN consecutive
// synchronised samples that all differ from its current value.
module ps2_line_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  localparam int unsigned CntW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   sample;

  assign sample = sync_q[SYNC_STAGES-1];
  assign filt   = filt_q;

  // Synchroniser chain; resets to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Count consecutive samples that disagree with the filtered level; flip on the last one.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sample == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(FILTER_LEN - 1)) begin
      filt_d = sample;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Filter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: conditions the raw lines, detects PS/2 clock
// falling edges, deserialises 11-bit frames and emits one-cycle result strobes.
// Optional feature macro: PS2_RX_TIMEOUT_EN (drops a stalled partial frame with frame_err).
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned BitCntW = $clog2(PS2_DATA_BITS);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic filt_clk, filt_data;
  logic filt_clk_q;
  logic fall_q;

  ps2_rx_state_t      state_q, state_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]         sr_q, sr_d;
  logic               par_ok_q, par_ok_d;
  logic [7:0]         byte_q, byte_d;
  logic               byte_valid_q, byte_valid_d;
  logic               parity_err_q, parity_err_d;
  logic               frame_err_q, frame_err_d;
  logic               tmo_hit;

  ps2_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_clk_filter (
    .clk  (clk),
    .rst  (rst),
    .raw  (ps2_clk_in),
    .filt (filt_clk)
  );

  ps2_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_data_filter (
    .clk  (clk),
    .rst  (rst),
    .raw  (ps2_data_in),
    .filt (filt_data)
  );

  // Registered falling-edge strobe of the filtered PS/2 clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_clk_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      filt_clk_q <= filt_clk;
      fall_q     <= filt_clk_q & ~filt_clk;
    end
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Idle counter: restarts on every PS/2 edge and whenever no frame is in progress.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == IDLE || fall_q) begin
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  assign tmo_hit = (state_q != IDLE) && (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

  // Idle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Frame FSM next state; a timeout beats a coincident edge, which is then discarded.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    sr_d         = sr_q;
    par_ok_d     = par_ok_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    if (tmo_hit) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      frame_err_d = 1'b1;
    end else if (fall_q) begin
      unique case (state_q)
        IDLE: begin
          // A high data line on an edge is a spurious edge, not a start bit.
          if (!filt_data) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          sr_d      = {filt_data, sr_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BitCntW'(PS2_DATA_BITS - 1)) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_ok_d = ps2_odd_parity_ok({sr_q, filt_data});
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!filt_data) begin
            frame_err_d = 1'b1;
          end else if (!par_ok_q) begin
            parity_err_d = 1'b1;
          end else begin
            byte_d       = sr_q;
            byte_valid_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame FSM and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      sr_q         <= '0;
      par_ok_q     <= 1'b0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      sr_q         <= sr_d;
      par_ok_q     <= par_ok_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = byte_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: stimulus pushes expected strobes, a monitor pops them.
module tb_ps2_rx_frame;

  localparam int unsigned FilterLen = 4;
  localparam int unsigned TmoCycles = 1000;

  localparam int KValid  = 0;
  localparam int KParity = 1;
  localparam int KFrame  = 2;

  typedef struct {
    int         kind;
    logic [7:0] b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk_in = 1'b1;
  logic       ps2_data_in = 1'b1;
  logic [7:0] byte_out;
  logic       byte_valid, parity_err, frame_err, busy;

  int         checks = 0;
  int         errors = 0;
  exp_t       exp_q[$];
  logic [7:0] last_good = 8'h00;

  ps2_rx_frame #(
    .SYNC_STAGES    (2),
    .FILTER_LEN     (FilterLen),
    .TIMEOUT_CYCLES (TmoCycles)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst && (byte_valid || parity_err || frame_err)) begin
      int   act_kind;
      exp_t e;
      act_kind = byte_valid ? KValid : (parity_err ? KParity : KFrame);
      checks++;
      if ((32'(byte_valid) + 32'(parity_err) + 32'(frame_err)) != 1) begin
        errors++;
        $display("FAIL one_hot_pulse: valid=%0b parity=%0b frame=%0b, need exactly one",
                 byte_valid, parity_err, frame_err);
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got kind %0d byte %h, none expected", act_kind,
                 byte_out);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (act_kind != e.kind || byte_out !== e.b) begin
          errors++;
          $display("FAIL scoreboard: got kind %0d byte %h, expected kind %0d byte %h",
                   act_kind, byte_out, e.kind, e.b);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] b);
    exp_t e;
    e.kind = kind;
    e.b    = b;
    exp_q.push_back(e);
  endtask

  // Low pulse on the raw clock just shorter than the filter length.
  task automatic clk_glitch();
    ps2_clk_in = 1'b0;
    wait_clk(FilterLen - 1);
    ps2_clk_in = 1'b1;
  endtask

  // One bit cell: data changes mid-high, clock low 20, clock high 20 (period 40 clk).
  task automatic send_bit(input logic v, input bit glitch);
    ps2_data_in = v;
    if (glitch) begin
      wait_clk(4);
      clk_glitch();
      wait_clk(3);
    end else begin
      wait_clk(10);
    end
    ps2_clk_in = 1'b0;
    wait_clk(20);
    ps2_clk_in = 1'b1;
    wait_clk(10);
  endtask

  // Sends the first nbits of a frame: start, 8 data LSB-first, parity, stop.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop,
                            input int glitch_bit, input int nbits);
    logic [10:0] bits;
    bits[0]   = 1'b0;
    bits[8:1] = b;
    bits[9]   = ~(^b) ^ bad_par;
    bits[10]  = stop;
    for (int i = 0; i < nbits; i++) send_bit(bits[i], i == glitch_bit);
    ps2_data_in = 1'b1;
    wait_clk(10);
  endtask

  task automatic good_frame(input logic [7:0] b, input int glitch_bit);
    push(KValid, b);
    last_good = b;
    send_frame(b, 1'b0, 1'b1, glitch_bit, 11);
  endtask

  initial begin
    wait_clk(5);
    check("reset_byte_out", byte_out, 8'h00);
    check("reset_pulses", {5'b0, byte_valid, parity_err, frame_err}, 8'h00);
    check("reset_busy", {7'b0, busy}, 8'h00);
    rst = 1'b0;
    wait_clk(10);
    check("idle_busy", {7'b0, busy}, 8'h00);

    // Single good frame.
    good_frame(8'h1C, -1);
    check("t1_byte_out", byte_out, 8'h1C);
    check("t1_busy_after", {7'b0, busy}, 8'h00);

    // Back-to-back frames.
    good_frame(8'hF0, -1);
    good_frame(8'h1C, -1);
    check("t2_byte_out", byte_out, 8'h1C);

    // Inverted parity bit: parity error, byte_out held.
    push(KParity, last_good);
    send_frame(8'h22, 1'b1, 1'b1, -1, 11);
    check("t3_byte_out_held", byte_out, 8'h1C);

    // Stop bit low: frame error, then a good retry.
    push(KFrame, last_good);
    send_frame(8'h1D, 1'b0, 1'b0, -1, 11);
    check("t4_byte_out_held", byte_out, 8'h1C);
    good_frame(8'h1D, -1);
    check("t4_byte_out", byte_out, 8'h1D);

    // Short clock glitches in idle and mid-data are ignored.
    clk_glitch();
    wait_clk(12);
    check("t5_idle_glitch_busy", {7'b0, busy}, 8'h00);
    good_frame(8'h2A, 4);
    check("t5_byte_out", byte_out, 8'h2A);

`ifdef PS2_RX_TIMEOUT_EN
    // Stall after five data bits: timeout drops the partial frame.
    push(KFrame, last_good);
    send_frame(8'h0F, 1'b0, 1'b1, -1, 6);
    check("t6_busy_stalled", {7'b0, busy}, 8'h01);
    wait_clk(TmoCycles + 20);
    check("t6_busy_after_timeout", {7'b0, busy}, 8'h00);
    check("t6_byte_out_held", byte_out, 8'h2A);
    good_frame(8'h15, -1);
    check("t6_byte_out", byte_out, 8'h15);
`endif

    // Reset mid-frame: abort with no strobe.
    send_frame(8'h33, 1'b0, 1'b1, -1, 5);
    check("rst_busy_before", {7'b0, busy}, 8'h01);
    rst = 1'b1;
    wait_clk(3);
    check("rst_byte_out", byte_out, 8'h00);
    check("rst_pulses", {5'b0, byte_valid, parity_err, frame_err}, 8'h00);
    check("rst_busy", {7'b0, busy}, 8'h00);
    rst = 1'b0;
    last_good = 8'h00;
    wait_clk(10);
    good_frame(8'h15, -1);
    check("rst_recover_byte_out", byte_out, 8'h15);

    wait_clk(20);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: %0d expected strobes never seen, expected 0",
               exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
